clock_set_ctrl: RTL and testbench

//  Sequencer for the hh:mm:ss time-of-day chain built from BCD counters
//  (sec and min are mod-60, hr is mod-24). All counters are external.
//  - Generates the 1 Hz count enable.
//  - Gates the carry chain between the counters.
//  - Runs a two-button time-set mode that writes hours and minutes through

---
 rtl/clock_set_ctrl_pkg.sv | 26 ++
 rtl/clock_set_ctrl_tick_gen.sv | 33 +++
 rtl/clock_set_ctrl.sv | 156 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// Shared constants for the time-of-day set controller: state codes, BCD
// field limits and the load-target selector.
package clock_set_ctrl_pkg;

    // Legacy-compatible 2-bit state codes
    // state      | meaning
    // ST_RUN     | clock running, carry chain live, buttons only change mode
    // ST_SET_HR  | chain frozen, inc_btn steps the hours field
    // ST_SET_MIN | chain frozen, inc_btn steps the minutes field
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_SET_HR  = 2'd1;
    localparam logic [1:0] ST_SET_MIN = 2'd2;

    // Largest legal value of each BCD field; anything at or above wraps to 00
    localparam logic [7:0] BCD_MAX_MS = 8'h59;
    localparam logic [7:0] BCD_MAX_HR = 8'h23;

    // Which counter the next registered load strobe goes to
    typedef enum logic [1:0] {
        LD_NONE = 2'd0,
        LD_SEC  = 2'd1,
        LD_MIN  = 2'd2,
        LD_HR   = 2'd3
    } load_sel_e;

endpackage

// File: rtl/clock_set_ctrl_tick_gen.sv
// Prescaler for the time-of-day chain: divides clk down to a one-cycle
// registered tick every DIV cycles. clr restarts the count so the first
// tick after a clear lands exactly DIV cycles later.
module tick_gen #(
    parameter int DIV   = 50_000_000,
    parameter int DIV_W = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] cnt;

    // Count 0..DIV-1 and emit tick the cycle after the terminal value
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CNT_LAST);
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Sequencer for an external hh:mm:ss BCD counter chain. Generates the 1 Hz
// count enable, gates the carry chain, and runs the two-button time-set
// mode that writes hours/minutes through the counters' load ports.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int DIV   = 50_000_000,
    parameter int DIV_W = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [7:0] sec_q,
    input  logic [7:0] min_q,
    input  logic [7:0] hr_q,
    input  logic       sec_co,
    input  logic       min_co,
    output logic       sec_cin,
    output logic       min_cin,
    output logic       hr_cin,
    output logic       sec_load,
    output logic       min_load,
    output logic       hr_load,
    output logic [7:0] ld_data,
    output logic       blink_hr,
    output logic       blink_min
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       tick;
    logic       clr_presc;
    logic       blink_phase;
    logic       busy;
    logic       inc_ok;
    logic       run_mode;
    load_sel_e  load_nxt;
    logic [7:0] ld_data_nxt;

    // The seconds value belongs to the counter bus but no decision here needs it
    logic unused_sec_q;
    assign unused_sec_q = ^sec_q;

    // Increment a BCD field, returning 00 at or above its maximum
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v >= max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'h9) begin
            r = {v[7:4] + 4'h1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'h1};
        end
        return r;
    endfunction

    tick_gen #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_presc),
        .tick  (tick)
    );

    // Leaving set mode restarts the second so the clock resumes on a full second
    assign clr_presc = (state == ST_SET_MIN) && mode_btn;

    // Mode button walks RUN -> SET_HR -> SET_MIN -> RUN; stray codes recover to RUN
    always_comb begin
        state_nxt = state;
        if (mode_btn) begin
            case (state)
                ST_RUN:    state_nxt = ST_SET_HR;
                ST_SET_HR: state_nxt = ST_SET_MIN;
                default:   state_nxt = ST_RUN;
            endcase
        end
    end

    // Pick the next load strobe and value; mode beats inc, and inc is dropped
    // while a previous load is still in flight so it never reads a stale q
    always_comb begin
        busy        = sec_load | min_load | hr_load;
        inc_ok      = inc_btn && !mode_btn && !busy;
        load_nxt    = LD_NONE;
        ld_data_nxt = 8'h00;
        case (state)
            ST_SET_HR: begin
                if (inc_ok) begin
                    load_nxt    = LD_HR;
                    ld_data_nxt = bcd_inc(hr_q, BCD_MAX_HR);
                end
            end
            ST_SET_MIN: begin
                if (mode_btn) begin
                    load_nxt    = LD_SEC;
                    ld_data_nxt = 8'h00;
                end else if (inc_ok) begin
                    load_nxt    = LD_MIN;
                    ld_data_nxt = bcd_inc(min_q, BCD_MAX_MS);
                end
            end
            default: begin
                load_nxt    = LD_NONE;
                ld_data_nxt = 8'h00;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered one-hot load strobes and the shared load value
    always_ff @(posedge clk) begin
        if (!reset) begin
            sec_load <= 1'b0;
            min_load <= 1'b0;
            hr_load  <= 1'b0;
            ld_data  <= 8'h00;
        end else begin
            sec_load <= (load_nxt == LD_SEC);
            min_load <= (load_nxt == LD_MIN);
            hr_load  <= (load_nxt == LD_HR);
            ld_data  <= ld_data_nxt;
        end
    end

    // Blink phase advances on each swallowed tick in set mode, parked low in RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_phase <= 1'b0;
        end else if (state == ST_RUN) begin
            blink_phase <= 1'b0;
        end else if (tick) begin
            blink_phase <= ~blink_phase;
        end
    end

    // Carry chain is a zero-latency pass-through so all fields roll on one edge
    assign run_mode  = (state == ST_RUN);
    assign sec_cin   = run_mode && tick;
    assign min_cin   = run_mode && sec_co;
    assign hr_cin    = run_mode && min_co;
    assign blink_hr  = (state == ST_SET_HR) && blink_phase;
    assign blink_min = (state == ST_SET_MIN) && blink_phase;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with DIV=4, driving a behavioural model of the
// external bcd60/bcd60/bcd24 counter chain. Load strobes are matched
// against a queue of expected loads filled as buttons are pressed.
module tb_clock_set_ctrl;

    localparam logic [2:0] K_HR  = 3'b100;
    localparam logic [2:0] K_MIN = 3'b010;
    localparam logic [2:0] K_SEC = 3'b001;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
    } ld_exp_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn  = 1'b0;
    logic [7:0] sec_q    = 8'h00;
    logic [7:0] min_q    = 8'h00;
    logic [7:0] hr_q     = 8'h00;
    logic       sec_co;
    logic       min_co;
    logic       sec_cin, min_cin, hr_cin;
    logic       sec_load, min_load, hr_load;
    logic [7:0] ld_data;
    logic       blink_hr, blink_min;

    logic       pre_en = 1'b0;
    logic [7:0] pre_h  = 8'h00;
    logic [7:0] pre_m  = 8'h00;
    logic [7:0] pre_s  = 8'h00;
    logic       mon_en = 1'b0;

    int         total = 0;
    int         bad   = 0;
    ld_exp_t    exp_q[$];
    ld_exp_t    mon_e;

    clock_set_ctrl #(
        .DIV   (4),
        .DIV_W (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .sec_q     (sec_q),
        .min_q     (min_q),
        .hr_q      (hr_q),
        .sec_co    (sec_co),
        .min_co    (min_co),
        .sec_cin   (sec_cin),
        .min_cin   (min_cin),
        .hr_cin    (hr_cin),
        .sec_load  (sec_load),
        .min_load  (min_load),
        .hr_load   (hr_load),
        .ld_data   (ld_data),
        .blink_hr  (blink_hr),
        .blink_min (blink_min)
    );

    always #5 clk = ~clk;

    // Next value of a BCD counter, computed through decimal arithmetic
    function automatic logic [7:0] bcd_next(input logic [7:0] q, input int modn);
        int v;
        v = int'(q[7:4]) * 10 + int'(q[3:0]);
        v = (v + 1) % modn;
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    // External counter chain model: load beats count, preload beats both
    always @(posedge clk) begin
        if (pre_en) begin
            hr_q  <= pre_h;
            min_q <= pre_m;
            sec_q <= pre_s;
        end else begin
            if (sec_load)     sec_q <= ld_data;
            else if (sec_cin) sec_q <= bcd_next(sec_q, 60);
            if (min_load)     min_q <= ld_data;
            else if (min_cin) min_q <= bcd_next(min_q, 60);
            if (hr_load)      hr_q  <= ld_data;
            else if (hr_cin)  hr_q  <= bcd_next(hr_q, 24);
        end
    end

    assign sec_co = (sec_q == 8'h59) && sec_cin;
    assign min_co = (min_q == 8'h59) && min_cin;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Match every load strobe against the scoreboard; idle ld_data must be 00
    always @(negedge clk) begin
        if (mon_en) begin
            if (sec_load || min_load || hr_load) begin
                if (exp_q.size() == 0) begin
                    check("load_unexpected", int'({hr_load, min_load, sec_load}), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("load_kind", int'({hr_load, min_load, sec_load}), int'(mon_e.kind));
                    check("load_data", int'(ld_data), int'(mon_e.data));
                end
            end else begin
                check("ld_data_idle", int'(ld_data), 0);
            end
        end
    end

    function automatic int all_outs();
        return int'({sec_cin, min_cin, hr_cin, sec_load, min_load, hr_load,
                     blink_hr, blink_min, ld_data});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mode();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
    endtask

    task automatic pulse_inc();
        inc_btn = 1'b1;
        step();
        inc_btn = 1'b0;
    endtask

    task automatic preload(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        pre_h  = h;
        pre_m  = m;
        pre_s  = s;
        pre_en = 1'b1;
        step();
        pre_en = 1'b0;
    endtask

    // Edges until sec_cin is seen (sampled at negedge); -1 if it never comes
    task automatic wait_cin(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sec_cin) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int toggles;
        logic prev;
        logic frozen_bad;
        logic [7:0] saved_sec;

        // Reset and tick cadence
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        check("reset_outs", all_outs(), 0);
        mon_en = 1'b1;
        wait_cin(n);
        check("first_cin", n, 4);
        wait_cin(n);
        check("cin_period", n, 4);
        check("sec_counted", int'(sec_q), 8'h01);

        // Full-chain rollover on a single edge
        step();
        preload(8'h00, 8'h59, 8'h59);
        wait_cin(n);
        check("roll_min_cin", int'(min_cin), 1);
        check("roll_hr_cin", int'(hr_cin), 1);
        step();
        check("rollover", int'({hr_q, min_q, sec_q}), 24'h010000);

        // Set hours 22 -> 23 -> 00, chain frozen, blink running
        preload(8'h22, 8'h59, 8'h10);
        pulse_mode();
        saved_sec = sec_q;
        exp_q.push_back('{K_HR, 8'h23});
        pulse_inc();
        step();
        step();
        exp_q.push_back('{K_HR, 8'h00});
        pulse_inc();
        step();
        step();
        check("hr_wrap", int'(hr_q), 8'h00);
        @(negedge clk);
        prev = blink_hr;
        toggles = 0;
        frozen_bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (blink_hr != prev) toggles++;
            prev = blink_hr;
            frozen_bad |= sec_cin | min_cin | hr_cin | blink_min;
        end
        check("blink_hr_toggles", toggles, 4);
        check("chain_frozen", int'(frozen_bad), 0);
        check("sec_frozen", int'(sec_q), int'(saved_sec));

        // Set minutes 59 -> 00; inc held into the load cycle is dropped
        pulse_mode();
        exp_q.push_back('{K_MIN, 8'h00});
        inc_btn = 1'b1;
        step();
        step();
        inc_btn = 1'b0;
        step();
        step();
        check("min_wrap", int'(min_q), 8'h00);
        check("hr_kept", int'(hr_q), 8'h00);

        // Exit to RUN: seconds loaded 00, first tick 4 cycles later
        exp_q.push_back('{K_SEC, 8'h00});
        pulse_mode();
        wait_cin(n);
        check("exit_cin", n, 4);
        check("sec_after_exit", int'(sec_q), 8'h00);

        // mode+inc together in SET_HR: advance, no hour load
        step();
        pulse_mode();
        mode_btn = 1'b1;
        inc_btn  = 1'b1;
        step();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        check("hr_not_loaded", int'(hr_q), 8'h00);
        preload(8'h05, 8'h12, 8'h30);
        exp_q.push_back('{K_MIN, 8'h13});
        pulse_inc();
        step();
        step();
        check("in_set_min", int'(min_q), 8'h13);
        exp_q.push_back('{K_SEC, 8'h00});
        pulse_mode();
        step();

        // Reset in the middle of SET_HR aborts with no load
        pulse_mode();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("midreset_outs", all_outs(), 0);
        wait_cin(n);
        check("midreset_cin", n, 4);
        pulse_inc();
        step();
        step();
        step();
        check("run_inc_ignored", int'(hr_q), 8'h05);
        check("blink_run", int'({blink_hr, blink_min}), 0);

        check("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
